// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key schedule controller: iterates one round of key expansion over
// ten cycles, stores all eleven round keys and serves them on a registered
// read port.

// Single AES-128 key-expansion round: key_new = next round key from key.
module ke (
  input  logic [127:0] key,
  input  logic [3:0]   rounds,
  output logic [127:0] key_new
);

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = '0;
    aa = a;
    bb = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box: multiplicative inverse as x^254 (maps 0 to 0), then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, s;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    s    = gf_mul(gf_mul(x240, x12), x2);
    return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]}
             ^ {s[3:0], s[7:4]} ^ 8'h63;
  endfunction

  logic [7:0]  rcon;
  logic [31:0] rot;
  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  // Round constant lookup; index 0 has no defined constant
  always_comb begin
    rcon = 8'h00;
    case (rounds)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // RotWord, SubWord, Rcon, then the chained word XORs
  always_comb begin
    rot  = {key[23:0], key[31:24]};
    temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
         ^ {rcon, 24'h000000};
    n0   = key[127:96] ^ temp;
    n1   = key[95:64]  ^ n0;
    n2   = key[63:32]  ^ n1;
    n3   = key[31:0]   ^ n2;
    key_new = {n0, n1, n2, n3};
  end

endmodule

module aes_key_schedule_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         keys_valid,
  output logic         done,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
);

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t       state;
  logic [3:0]   rnd;
  logic [127:0] cur_key;
  logic [127:0] key_new;
  logic [127:0] rk [0:NUM_ROUNDS];

  ke u_ke (
    .key     (cur_key),
    .rounds  (rnd),
    .key_new (key_new)
  );

  // Control FSM plus round-key file writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      done       <= 1'b0;
      rnd        <= '0;
      cur_key    <= '0;
      for (int unsigned i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rk[0]      <= key_in;
            cur_key    <= key_in;
            rnd        <= 4'd1;
            keys_valid <= 1'b0;
            busy       <= 1'b1;
            state      <= EXPAND;
          end
        end
        EXPAND: begin
          rk[rnd] <= key_new;
          cur_key <= key_new;
          if (rnd == 4'(NUM_ROUNDS)) begin
            busy       <= 1'b0;
            keys_valid <= 1'b1;
            done       <= 1'b1;
            rnd        <= '0;
            state      <= IDLE;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered read port; indices past the last round key read as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_key <= '0;
    end else if (rd_round <= 4'(NUM_ROUNDS)) begin
      rd_key <= rk[rd_round];
    end else begin
      rd_key <= '0;
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Self-checking bench for aes_key_schedule_ctrl against a word-oriented
// FIPS-197 key-expansion model.
module tb_aes_key_schedule_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         keys_valid;
  logic         done;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic [7:0]   sbox_t [0:255];
  logic [7:0]   rcon_t [1:10];
  logic [127:0] exp_rk [0:10];

  aes_key_schedule_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .keys_valid (keys_valid),
    .done       (done),
    .rd_round   (rd_round),
    .rd_key     (rd_key)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // S-box built by walking the multiplicative group with generator 3
  task automatic build_tables();
    logic [7:0] p, q, x, rc;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
    rc = 8'h01;
    for (int i = 1; i <= 10; i++) begin
      rcon_t[i] = rc;
      rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
    end
  endtask

  // Textbook 44-word expansion
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    w[0] = key[127:96];
    w[1] = key[95:64];
    w[2] = key[63:32];
    w[3] = key[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rcon_t[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Called at a negedge; returns at the negedge of the cycle where done is high
  task automatic run_schedule(input logic [127:0] key, input int unsigned inject_at);
    start  = 1'b1;
    key_in = key;
    for (int unsigned cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      if (cyc == inject_at) begin
        start  = 1'b1;
        key_in = '0;
      end else begin
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
      end
      chk($sformatf("busy_c%0d", cyc), 128'(busy), 128'(cyc <= 10));
      chk($sformatf("done_c%0d", cyc), 128'(done), 128'(cyc == 11));
      chk($sformatf("kv_c%0d", cyc), 128'(keys_valid), 128'(cyc == 11));
    end
    start = 1'b0;
  endtask

  task automatic read_one(input logic [3:0] r, input logic [127:0] exp, input string tag);
    rd_round = r;
    @(negedge clk);
    chk(tag, rd_key, exp);
  endtask

  task automatic read_all();
    for (int r = 0; r <= 10; r++) read_one(4'(r), exp_rk[r], $sformatf("rk%0d", r));
    chk("kv_hold", 128'(keys_valid), 128'(1));
  endtask

  initial begin
    logic [127:0] k;
    logic [3:0]   rr;
    build_tables();
    rst_n    = 1'b0;
    start    = 1'b0;
    key_in   = '0;
    rd_round = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_kv", 128'(keys_valid), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_rdkey", rd_key, 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 vector
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model_expand(k);
    run_schedule(k, 0);
    read_one(4'd1, 128'ha0fafe1788542cb123a339392a6c7605, "fips_rk1");
    read_one(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_rk10");
    read_one(4'd0, k, "fips_rk0");
    read_all();

    // Second start mid-expansion must be ignored
    run_schedule(k, 5);
    read_one(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "busy_start_rk10");

    // Re-key while keys_valid
    k = 128'h000102030405060708090a0b0c0d0e0f;
    model_expand(k);
    run_schedule(k, 0);
    read_one(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "rekey_rk10");
    read_all();

    // Out-of-range reads
    read_one(4'd11, 128'(0), "oor_11");
    chk("oor_kv11", 128'(keys_valid), 128'(1));
    read_one(4'd15, 128'(0), "oor_15");
    chk("oor_kv15", 128'(keys_valid), 128'(1));

    // Start coincident with done: back-to-back schedules
    k = {$urandom, $urandom, $urandom, $urandom};
    run_schedule(k, 0);
    k = {$urandom, $urandom, $urandom, $urandom};
    model_expand(k);
    run_schedule(k, 0);
    read_all();

    // Random reads, including out-of-range indices
    for (int i = 0; i < 20; i++) begin
      rr = 4'($urandom_range(0, 15));
      read_one(rr, (rr <= 4'd10) ? exp_rk[rr] : 128'(0), $sformatf("rand_rd%0d", rr));
    end

    // Asynchronous reset in cycle 6 of an expansion
    start  = 1'b1;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 128'(busy), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_kv", 128'(keys_valid), 128'(0));
    chk("arst_done", 128'(done), 128'(0));
    chk("arst_rdkey", rd_key, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    read_one(4'd10, 128'(0), "arst_rk10_cleared");
    chk("arst_kv_after", 128'(keys_valid), 128'(0));
    k = {$urandom, $urandom, $urandom, $urandom};
    model_expand(k);
    run_schedule(k, 0);
    read_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
